// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment BCD driver: glyph patterns, special codes,
// decimal range limits and the converter state type.
package sevenseg_pkg;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;

  // Smallest value that no longer fits in N decimal digits, indexed by N.
  localparam logic [31:0] DEC_LIMIT [9] = '{
    32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
    32'd1000000, 32'd10000000, 32'd100000000
  };

  typedef enum logic [1:0] {StIdle, StShift, StCommit} conv_state_e;

  // Segment pattern (g..a, active high) for one digit code.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    unique case (code)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_iter_convert.sv
// Iterative binary-to-digit converter: double dabble one bit per cycle for decimal,
// single-cycle nibble split for hex. start is sampled only while idle.
module bcd_iter_convert
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned WIDTH  = 20
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  hex,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);

  localparam int unsigned   SW    = WIDTH + 4 * DIGITS;
  localparam int unsigned   CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [31:0]   LIMIT = DEC_LIMIT[4'(DIGITS)];

  conv_state_e          state_q;
  logic [SW-1:0]        sr_q;
  logic [SW-1:0]        step;
  logic [SW-1:0]        value_pad;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_pend_q;
  logic                 start_ovf;
  logic                 done_q;
  logic [4*DIGITS-1:0]  digits_q;
  logic                 overflow_q;

  always_comb begin
    value_pad = SW'(value);
    start_ovf = hex ? ((value_pad >> (4 * DIGITS)) != '0) : (32'(value) >= LIMIT);
    // One double-dabble step on the BCD field sitting above the binary field.
    step = sr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (step[WIDTH+4*k +: 4] >= 4'd5) step[WIDTH+4*k +: 4] = step[WIDTH+4*k +: 4] + 4'd3;
    end
    step = step << 1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            ovf_pend_q <= start_ovf;
            cnt_q      <= '0;
            if (hex) begin
              sr_q    <= value_pad << WIDTH;
              state_q <= StCommit;
            end else begin
              sr_q    <= value_pad;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          sr_q  <= step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= StCommit;
        end
        StCommit: begin
          digits_q   <= sr_q[SW-1 -: 4*DIGITS];
          overflow_q <= ovf_pend_q;
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/sevenseg_bcd_driver.sv
// Multi-digit seven-segment driver: detects a new value, converts it to decimal or hex
// digits and drives registered segment patterns with blanking and overflow dashes.
module sevenseg_bcd_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned WIDTH      = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      number,
  input  logic [DIGITS-1:0]     seg_en,
  input  logic                  blank_lz,
  input  logic                  hex_mode,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic                  busy,
  output logic                  update,
  output logic                  overflow
);

  localparam logic [6:0] POLARITY = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [WIDTH:0]        last_pair_q;
  logic                  valid_q;
  logic                  shown_q;
  logic                  start;
  logic                  conv_busy;
  logic                  conv_done;
  logic                  conv_ovf;
  logic [4*DIGITS-1:0]   conv_digits;
  logic [7*DIGITS-1:0]   seg_d;
  logic [7*DIGITS-1:0]   seg_q;
  logic                  update_q;
  logic                  overflow_q;
  logic [3:0]            digit;
  logic [6:0]            pattern;
  logic                  seen_nz;
  logic                  lead_zero;

  // Every capture always commits (only reset aborts, and reset clears valid_q), so the
  // captured pair doubles as the last committed pair.
  assign start = !conv_busy && (!valid_q || ({number, hex_mode} != last_pair_q));

  bcd_iter_convert #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) u_conv (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .value    (number),
    .hex      (hex_mode),
    .busy     (conv_busy),
    .done     (conv_done),
    .digits   (conv_digits),
    .overflow (conv_ovf)
  );

  always_comb begin
    seg_d     = '0;
    seen_nz   = 1'b0;
    digit     = '0;
    pattern   = GLYPH_BLANK;
    lead_zero = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit     = conv_digits[4*k +: 4];
      lead_zero = blank_lz && !seen_nz && (digit == 4'd0) && (k != 0);
      seen_nz   = seen_nz | (digit != 4'd0);
      if (!seg_en[k] || !(shown_q || conv_done)) pattern = GLYPH_BLANK;
      else if (conv_ovf)                         pattern = GLYPH_DASH;
      else if (lead_zero)                        pattern = GLYPH_BLANK;
      else                                       pattern = glyph(digit);
      seg_d[7*k +: 7] = pattern ^ POLARITY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_pair_q <= '0;
      valid_q     <= 1'b0;
      shown_q     <= 1'b0;
      seg_q       <= {DIGITS{POLARITY}};
      update_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (start) begin
        last_pair_q <= {number, hex_mode};
        valid_q     <= 1'b1;
      end
      shown_q    <= shown_q | conv_done;
      seg_q      <= seg_d;
      update_q   <= conv_done;
      overflow_q <= conv_ovf;
    end
  end

  assign seg_out  = seg_q;
  assign busy     = conv_busy;
  assign update   = update_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sevenseg_bcd_driver.sv
// Directed bench for sevenseg_bcd_driver: default instance plus a 4-digit/14-bit instance.
module tb_sevenseg_bcd_driver;

  logic        clock;
  logic        reset_n;
  logic [19:0] number;
  logic [5:0]  seg_en;
  logic        blank_lz;
  logic        hex_mode;
  logic [41:0] seg_out;
  logic        busy;
  logic        upd;
  logic        overflow;

  logic [13:0] number4;
  logic [3:0]  seg_en4;
  logic        blank_lz4;
  logic        hex_mode4;
  logic [27:0] seg_out4;
  logic        busy4;
  logic        upd4;
  logic        overflow4;

  int total = 0;
  int bad   = 0;
  int cyc;
  int nup;
  logic [41:0] first_seg;

  sevenseg_bcd_driver u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .number   (number),
    .seg_en   (seg_en),
    .blank_lz (blank_lz),
    .hex_mode (hex_mode),
    .seg_out  (seg_out),
    .busy     (busy),
    .update   (upd),
    .overflow (overflow)
  );

  sevenseg_bcd_driver #(
    .DIGITS (4),
    .WIDTH  (14)
  ) u_dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .number   (number4),
    .seg_en   (seg_en4),
    .blank_lz (blank_lz4),
    .hex_mode (hex_mode4),
    .seg_out  (seg_out4),
    .busy     (busy4),
    .update   (upd4),
    .overflow (overflow4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges from the call (inputs just driven) until update is seen; -1 on timeout.
  task automatic wait_upd(input bit sel, output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (sel ? upd4 : upd) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    number    = '0;
    seg_en    = '1;
    blank_lz  = 1'b1;
    hex_mode  = 1'b0;
    number4   = '0;
    seg_en4   = '1;
    blank_lz4 = 1'b0;
    hex_mode4 = 1'b0;
    repeat (3) @(negedge clock);

    check("reset_seg", 64'(seg_out), 64'({6{7'h7F}}));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_update", 64'(upd), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    check("reset_seg4", 64'(seg_out4), 64'({4{7'h7F}}));

    // Zero after reset release must still convert; 22 cycles from capture to update.
    reset_n = 1'b1;
    wait_upd(1'b0, cyc);
    check("zero_latency", 64'(cyc), 64'd23);
    check("zero_seg_lz", 64'(seg_out), 64'({{5{7'h7F}}, 7'h40}));
    check("zero_ovf", 64'(overflow), 64'd0);
    check("zero_busy_done", 64'(busy), 64'd0);

    blank_lz = 1'b0;
    @(negedge clock);
    check("zero_seg_nolz", 64'(seg_out), 64'({6{7'h40}}));
    check("nolz_no_update", 64'(upd), 64'd0);
    blank_lz = 1'b1;

    number = 20'd1234;
    wait_upd(1'b0, cyc);
    check("d1234_latency", 64'(cyc), 64'd23);
    check("d1234_seg", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
    check("d1234_ovf", 64'(overflow), 64'd0);
    @(negedge clock);
    check("d1234_pulse_once", 64'(upd), 64'd0);

    seg_en = 6'b111110;
    @(negedge clock);
    check("segen_blank_d0", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h7F}));
    check("segen_no_update", 64'(upd), 64'd0);
    check("segen_no_busy", 64'(busy), 64'd0);
    seg_en = '1;

    // Hex: capture E0, commit E1, display/update E2.
    number   = 20'hABCDE;
    hex_mode = 1'b1;
    @(negedge clock);
    check("hex_busy_e0", 64'(busy), 64'd1);
    check("hex_upd_e0", 64'(upd), 64'd0);
    @(negedge clock);
    check("hex_busy_e1", 64'(busy), 64'd0);
    check("hex_upd_e1", 64'(upd), 64'd0);
    @(negedge clock);
    check("hex_upd_e2", 64'(upd), 64'd1);
    check("hex_seg", 64'(seg_out), 64'({7'h7F, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06}));
    @(negedge clock);
    check("hex_upd_e3", 64'(upd), 64'd0);

    hex_mode = 1'b0;
    number   = 20'd1000000;
    wait_upd(1'b0, cyc);
    check("d1e6_seg_dash", 64'(seg_out), 64'({6{7'h3F}}));
    check("d1e6_ovf", 64'(overflow), 64'd1);
    seg_en = 6'b011111;
    @(negedge clock);
    check("d1e6_segen_blank", 64'(seg_out), 64'({7'h7F, {5{7'h3F}}}));
    seg_en = '1;

    number = 20'd999999;
    wait_upd(1'b0, cyc);
    check("d999999_seg", 64'(seg_out), 64'({6{7'h10}}));
    check("d999999_ovf", 64'(overflow), 64'd0);

    number4 = 14'd10000;
    wait_upd(1'b1, cyc);
    check("w4_latency", 64'(cyc), 64'd17);
    check("w4_10000_seg", 64'(seg_out4), 64'({4{7'h3F}}));
    check("w4_10000_ovf", 64'(overflow4), 64'd1);
    number4 = 14'd9999;
    wait_upd(1'b1, cyc);
    check("w4_9999_seg", 64'(seg_out4), 64'({4{7'h10}}));
    check("w4_9999_ovf", 64'(overflow4), 64'd0);

    // Change during conversion: 5 commits first, then 7 is re-detected.
    number = 20'd5;
    repeat (3) @(negedge clock);
    number    = 20'd7;
    nup       = 0;
    first_seg = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (upd) begin
        nup++;
        if (nup == 1) first_seg = seg_out;
      end
    end
    check("chg_update_count", 64'(nup), 64'd2);
    check("chg_first_seg", 64'(first_seg), 64'({{5{7'h7F}}, 7'h12}));
    check("chg_final_seg", 64'(seg_out), 64'({{5{7'h7F}}, 7'h78}));

    // Reset mid-conversion aborts; reconversion follows release.
    number = 20'd123;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_seg", 64'(seg_out), 64'({6{7'h7F}}));
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_update", 64'(upd), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_upd(1'b0, cyc);
    check("midrst_reconv_latency", 64'(cyc), 64'd23);
    check("midrst_reconv_seg", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
